ft240x_tx_arbiter: RTL
======================

# ft240x_tx_arbiter

Shares the FT240X FIFO write port between two byte sources and sequences the WR# strobe. The two sources are:
- the exfiltration path: target address-bus low bytes captured on an address match;
- the command FSM's response channel: status and readback bytes.

Exfiltration bytes arrive asynchronously to host flow control, so they are buffered in a small FIFO. The block also grants the shared ft240x_d bus to the command FSM's read sequences, so RD# and WR# activity never overlap. It sits between the command FSM / exfiltration match logic and the FT240X pins; the top level builds the ft240x_d tristate from d_out/d_oe.

## Interface
Parameters:
- FIFO_DEPTH, 4: exfiltration FIFO entries; power of two, ≥2.
- STROBE_CYCLES, 2: clk24MHz cycles WR# is held low; ≥1.

Ports:
- clk24MHz  in  1  system clock, 24 MHz.
- reset  in  1  synchronous, active-high reset.
- exfil_valid  in  1  one-cycle pulse: push exfil_data into the FIFO.
- exfil_data  in  8  byte to exfiltrate.
- resp_valid  in  1  response byte offered; held until accepted.
- resp_data  in  8  response byte; stable while resp_valid is high.
- resp_ready  out  1  one-cycle accept pulse for the response.
- rd_req  in  1  command FSM requests the bus for a read; held high for the entire RD# sequence.
- rd_grant  out  1  bus granted to the read side.
- ft240x_TXE  in  1  high means the FT240X TX FIFO is full.
- ft240x_d_out  out  8  byte driven toward the FT240X.
- ft240x_d_oe  out  1  1 = drive ft240x_d.
- ft240x_nWR  out  1  FT240X write strobe, active low.
- tx_busy  out  1  a write sequence is in progress.
- ovf_clear  in  1  clears ovf_flag and drop_count.
- ovf_flag  out  1  sticky: at least one exfiltration byte was dropped.
- drop_count  out  8  dropped-byte count; saturates at 255.

## Operation
- **Exfiltration FIFO**
  - FIFO_DEPTH entries, with read/write pointers plus an occupancy counter.
  - An exfil_valid pulse while the FIFO is not full writes exfil_data.
  - An exfil_valid pulse while full discards the byte, sets ovf_flag and increments drop_count (saturating).
  - A push and a pop in the same cycle on a full FIFO: the pop takes effect first, so the push is accepted and nothing is dropped.
  - The occupancy counter never exceeds FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH.
- **ovf_clear** clears ovf_flag and drop_count. If a drop occurs in the same cycle, the result is ovf_flag=1 and drop_count=1.
- **FSM states**
  - IDLE: ft240x_d_oe=0, ft240x_nWR=1.
  - SETUP: 1 cycle; data driven, ft240x_nWR=1.
  - STROBE: STROBE_CYCLES cycles; ft240x_nWR=0.
  - HOLD: 1 cycle; ft240x_nWR=1, data still driven.
  - After HOLD the FSM returns to IDLE.
- **Launch from IDLE** happens when all of the following hold: rd_req=0, ft240x_TXE=0, and a source is pending.
  - On launch, the selected byte is latched into the output register and the FSM moves to SETUP.
  - Latching the response byte pulses resp_ready for that same cycle.
  - Latching an exfiltration byte pops the FIFO in that same cycle.
- **Arbitration:** round-robin between the FIFO (not empty) and the response channel (resp_valid).
  - A last-grant bit toggles on each launch where both sources were pending.
  - When only one source is pending, it wins and the last-grant bit is updated to that source.
  - After reset, the response channel has priority.
- **Read-side grant:** rd_grant = rd_req && state==IDLE.
  - Reads take precedence over writes: rd_req high blocks any new launch.
  - rd_req rising during SETUP/STROBE/HOLD waits; rd_grant rises in the cycle the FSM returns to IDLE.
- **TXE** is sampled only in IDLE. TXE rising mid-sequence does not abort the byte.
- **tx_busy** = state != IDLE.
- **Reset mid-sequence:** the FSM forces IDLE and ft240x_nWR=1 on the next edge. The FIFO is emptied and the in-flight byte is lost.

## Timing
- Reset values:
  - ft240x_nWR=1, ft240x_d_oe=0, ft240x_d_out=0x00.
  - resp_ready=0, rd_grant=0, tx_busy=0.
  - ovf_flag=0, drop_count=0.
  - FIFO empty, last-grant=exfil (so the response channel wins first).
- All outputs are registered except rd_grant and tx_busy, which are decoded combinationally from the state register.
- Launch to ft240x_nWR falling: 2 cycles (the launch edge puts the FSM in SETUP; the next edge enters STROBE).
- Byte period for back-to-back bytes: 3+STROBE_CYCLES cycles when the next byte launches in the first IDLE cycle after HOLD. That is 5 cycles (~208 ns) at default.
- ft240x_d_out is stable from SETUP through HOLD, giving ≥1 cycle of setup and ≥1 cycle of hold around WR#.
- An exfil_valid pulse on an empty FIFO in IDLE can launch on the following cycle (one cycle of FIFO write latency).

## Test plan
- **Response write:** after reset, resp_valid=1, resp_data=0xA5, TXE=0.
  - resp_ready pulses once.
  - ft240x_nWR is low for exactly 2 cycles with d_out=0xA5 and d_oe high from SETUP through HOLD.
  - tx_busy is high for 4 cycles.
- **Round-robin:** FIFO preloaded with 0x11, 0x22; resp_valid held with 0x33.
  - Write order is 0x33, 0x11, 0x33(next resp byte), 0x22.
  - No cycle ever has nWR low and rd_grant high simultaneously.
- **FIFO overflow:** TXE=1; 6 exfil pulses with 0x01..0x06.
  - ovf_flag=1, drop_count=2.
  - Releasing TXE writes 0x01..0x04 in order.
  - ovf_clear returns ovf_flag=0, drop_count=0.
- **Read precedence:** rd_req rises in the STROBE cycle.
  - rd_grant stays 0 until HOLD completes, then goes to 1.
  - A pending FIFO byte is not launched until rd_req falls.
- **TXE gating:** TXE=1 with a byte pending.
  - ft240x_nWR stays high indefinitely.
  - After TXE falls, nWR falls exactly 2 cycles later.
  - TXE rising during STROBE does not shorten the strobe.
- **Reset mid-STROBE:**
  - The next cycle has ft240x_nWR=1, d_oe=0, FIFO empty and ovf_flag=0.
  - No spurious resp_ready pulse occurs.

Source files
------------

// File: rtl/ft240x_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ft240x_tx_arbiter
// Purpose  : Shares the FT240X FIFO write port between a buffered
//            exfiltration byte stream and the command FSM response channel.
//            It sequences WR# as SETUP / STROBE / HOLD and yields the shared
//            data bus to the read side while idle.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   FIFO_DEPTH     exfiltration FIFO entries (power of two, >= 2)
//   STROBE_CYCLES  clk24MHz cycles WR# is held low (>= 1)
// Ports
//   clk24MHz, reset          system clock, synchronous active-high reset
//   exfil_valid/exfil_data   one-cycle push into the exfiltration FIFO
//   resp_valid/resp_data     response byte offered until resp_ready pulses
//   resp_ready               one-cycle accept pulse for the response byte
//   rd_req / rd_grant        read-side bus request / grant (grant while idle)
//   ft240x_TXE               FT240X TX FIFO full (sampled only when idle)
//   ft240x_d_out/_d_oe       data toward FT240X and its output enable
//   ft240x_nWR               write strobe, active low
//   tx_busy                  a write sequence is in progress
//   ovf_clear                clears ovf_flag and drop_count
//   ovf_flag / drop_count    sticky drop flag / saturating drop counter
// ============================================================================
module ft240x_tx_arbiter #(
  parameter int FIFO_DEPTH    = 4,
  parameter int STROBE_CYCLES = 2
) (
  input  logic       clk24MHz,
  input  logic       reset,
  input  logic       exfil_valid,
  input  logic [7:0] exfil_data,
  input  logic       resp_valid,
  input  logic [7:0] resp_data,
  output logic       resp_ready,
  input  logic       rd_req,
  output logic       rd_grant,
  input  logic       ft240x_TXE,
  output logic [7:0] ft240x_d_out,
  output logic       ft240x_d_oe,
  output logic       ft240x_nWR,
  output logic       tx_busy,
  input  logic       ovf_clear,
  output logic       ovf_flag,
  output logic [7:0] drop_count
);

  localparam int c_addr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_cnt_w  = $clog2(FIFO_DEPTH + 1);
  localparam int c_strb_w = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

  localparam logic [c_cnt_w-1:0]  c_full        = c_cnt_w'(FIFO_DEPTH);
  localparam logic [c_strb_w-1:0] c_strobe_last = c_strb_w'(STROBE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t              r_state;
  logic [c_strb_w-1:0] r_strb_cnt;
  logic [7:0]          r_mem [FIFO_DEPTH];
  logic [c_addr_w-1:0] r_wptr;
  logic [c_addr_w-1:0] r_rptr;
  logic [c_cnt_w-1:0]  r_count;
  logic                r_last_exfil;   // 1: last grant went to the FIFO
  logic [7:0]          r_d_out;
  logic                r_d_oe;
  logic                r_nwr;
  logic                r_resp_ready;
  logic                r_ovf;
  logic [7:0]          r_drop;

  logic w_empty;
  logic w_full;
  logic w_launch;
  logic w_pick_exfil;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == c_full);

  // Reads own the bus whenever they ask; TXE is only looked at before a byte
  // is committed, so a sequence that has started always completes.
  assign w_launch = (r_state == ST_IDLE) && !rd_req && !ft240x_TXE &&
                    (!w_empty || resp_valid);

  // Round-robin: with both sources pending, serve the one not granted last.
  assign w_pick_exfil = !w_empty && (!resp_valid || !r_last_exfil);
  assign w_pop        = w_launch && w_pick_exfil;

  // A pop in the same cycle frees a slot, so a push into a full FIFO survives.
  assign w_push = exfil_valid && (!w_full || w_pop);
  assign w_drop = exfil_valid && w_full && !w_pop;

  // --------------------------------------------------------------------------
  // Exfiltration FIFO
  // --------------------------------------------------------------------------
  always_ff @(posedge clk24MHz) begin
    if (w_push) begin
      r_mem[r_wptr] <= exfil_data;
    end
  end

  always_ff @(posedge clk24MHz) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_addr_w'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_addr_w'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Overflow bookkeeping; a drop coinciding with a clear counts as the first
  // drop after the clear.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk24MHz) begin
    if (reset) begin
      r_ovf  <= 1'b0;
      r_drop <= 8'h00;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
      if (ovf_clear) begin
        r_drop <= 8'h01;
      end else if (r_drop != 8'hFF) begin
        r_drop <= r_drop + 8'h01;
      end
    end else if (ovf_clear) begin
      r_ovf  <= 1'b0;
      r_drop <= 8'h00;
    end
  end

  // --------------------------------------------------------------------------
  // Write sequencer with registered pin outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk24MHz) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_strb_cnt   <= '0;
      r_d_out      <= 8'h00;
      r_d_oe       <= 1'b0;
      r_nwr        <= 1'b1;
      r_resp_ready <= 1'b0;
      r_last_exfil <= 1'b1;
    end else begin
      r_resp_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_launch) begin
            r_d_out      <= w_pick_exfil ? r_mem[r_rptr] : resp_data;
            r_d_oe       <= 1'b1;
            r_resp_ready <= !w_pick_exfil;
            r_last_exfil <= w_pick_exfil;
            r_state      <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_nwr      <= 1'b0;
          r_strb_cnt <= '0;
          r_state    <= ST_STROBE;
        end
        ST_STROBE: begin
          if (r_strb_cnt == c_strobe_last) begin
            r_nwr   <= 1'b1;
            r_state <= ST_HOLD;
          end else begin
            r_strb_cnt <= r_strb_cnt + c_strb_w'(1);
          end
        end
        ST_HOLD: begin
          r_d_oe  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_nwr   <= 1'b1;
          r_d_oe  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rd_grant     = rd_req && (r_state == ST_IDLE);
  assign tx_busy      = (r_state != ST_IDLE);
  assign resp_ready   = r_resp_ready;
  assign ft240x_d_out = r_d_out;
  assign ft240x_d_oe  = r_d_oe;
  assign ft240x_nWR   = r_nwr;
  assign ovf_flag     = r_ovf;
  assign drop_count   = r_drop;

endmodule
`default_nettype wire
